// File: rtl/accumulator_window_sequencer.sv
// accumulator_window_sequencer
// Feeds a valid/ready sample stream into a signed saturating accumulator.
// Every window_length samples it reads back the sum and a sticky overflow flag
// and presents them on a valid/ready result port.
// Optional feature macro: ACC_WINDOW_BIAS_EN. When it is defined, each window
// starts by loading window_bias into the accumulator instead of clearing it.
module accumulator_window_sequencer #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] window_length,
  input  logic [WORD_WIDTH-1:0]  sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
`ifdef ACC_WINDOW_BIAS_EN
  input  logic [WORD_WIDTH-1:0]  window_bias,
`endif
  output logic [WORD_WIDTH-1:0]  acc_increment,
  output logic                   acc_increment_valid,
  output logic [WORD_WIDTH-1:0]  acc_load_value,
  output logic                   acc_load_valid,
  output logic                   acc_clear,
  input  logic [WORD_WIDTH-1:0]  acc_value,
  input  logic                   acc_overflow,
  output logic [WORD_WIDTH-1:0]  result_out,
  output logic                   result_overflow,
  output logic                   result_valid,
  input  logic                   result_ready
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [COUNT_WIDTH-1:0] r_length;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_sticky;
  logic [WORD_WIDTH-1:0]  r_result;
  logic                   r_result_ovf;
  logic                   r_result_valid;
  logic                   w_accept;
  logic                   w_last;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and accumulator-facing controls
  always_comb begin
    w_next_state        = r_state;
    sample_ready        = 1'b0;
    acc_increment       = '0;
    acc_increment_valid = 1'b0;
    acc_load_value      = '0;
    acc_load_valid      = 1'b0;
    acc_clear           = 1'b0;
    w_accept            = 1'b0;
    w_last              = 1'b0;
    case (r_state)
      ST_START: begin
`ifdef ACC_WINDOW_BIAS_EN
        acc_load_valid = 1'b1;
        acc_load_value = window_bias;
`else
        acc_clear      = 1'b1;
`endif
        w_next_state   = ST_ACCUM;
      end
      ST_ACCUM: begin
        sample_ready        = 1'b1;
        acc_increment       = sample_in;
        acc_increment_valid = sample_valid;
        w_accept            = sample_valid;
        w_last              = sample_valid && (r_count == (r_length - COUNT_WIDTH'(1)));
        if (w_last) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_next_state = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (r_result_valid && result_ready) begin
          w_next_state = ST_START;
        end
      end
      default: begin
        w_next_state = ST_START;
      end
    endcase
  end

  // Window bookkeeping, sticky overflow capture and result register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_length       <= '0;
      r_count        <= '0;
      r_sticky       <= 1'b0;
      r_result       <= '0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          r_length <= (window_length == '0) ? COUNT_WIDTH'(1) : window_length;
          r_count  <= '0;
          r_sticky <= 1'b0;
        end
        ST_ACCUM: begin
          r_sticky <= r_sticky | acc_overflow;
          if (w_accept) begin
            r_count <= r_count + COUNT_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          r_sticky       <= r_sticky | acc_overflow;
          r_result       <= acc_value;
          r_result_ovf   <= r_sticky | acc_overflow;
          r_result_valid <= 1'b1;
        end
        ST_OUTPUT: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
          end
        end
        default: begin
          r_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result_out      = r_result;
  assign result_overflow = r_result_ovf;
  assign result_valid    = r_result_valid;

endmodule

// File: tb/tb_accumulator_window_sequencer.sv
// Directed bench for accumulator_window_sequencer with a behavioural
// signed saturating accumulator (limits +/-32767) attached.
module tb_accumulator_window_sequencer;

  localparam int unsigned WW = 16;
  localparam int unsigned CW = 8;
`ifdef ACC_WINDOW_BIAS_EN
  localparam logic EXP_CLR = 1'b0;
`else
  localparam logic EXP_CLR = 1'b1;
`endif

  logic          clock;
  logic          reset;
  logic [CW-1:0] window_length;
  logic [WW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [WW-1:0] window_bias;
  logic [WW-1:0] acc_increment;
  logic          acc_increment_valid;
  logic [WW-1:0] acc_load_value;
  logic          acc_load_valid;
  logic          acc_clear;
  logic [WW-1:0] acc_value;
  logic          acc_overflow;
  logic [WW-1:0] result_out;
  logic          result_overflow;
  logic          result_valid;
  logic          result_ready;

  int n_tests = 0;
  int n_fail  = 0;

  accumulator_window_sequencer #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .clock               (clock),
    .reset               (reset),
    .window_length       (window_length),
    .sample_in           (sample_in),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready),
`ifdef ACC_WINDOW_BIAS_EN
    .window_bias         (window_bias),
`endif
    .acc_increment       (acc_increment),
    .acc_increment_valid (acc_increment_valid),
    .acc_load_value      (acc_load_value),
    .acc_load_valid      (acc_load_valid),
    .acc_clear           (acc_clear),
    .acc_value           (acc_value),
    .acc_overflow        (acc_overflow),
    .result_out          (result_out),
    .result_overflow     (result_overflow),
    .result_valid        (result_valid),
    .result_ready        (result_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Accumulator model: overflow flag reflects only the most recent operation
  logic [WW-1:0] m_val;
  logic          m_ovf;

  function automatic logic [WW:0] sat_add(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic signed [WW:0] s;
    s = $signed({a[WW-1], a}) + $signed({b[WW-1], b});
    if (s > 17'sd32767)       return {1'b1, 16'h7fff};
    else if (s < -17'sd32767) return {1'b1, 16'h8001};
    else                      return {1'b0, s[WW-1:0]};
  endfunction

  always @(posedge clock) begin
    if (acc_clear) begin
      m_val <= '0;
      m_ovf <= 1'b0;
    end else if (acc_load_valid) begin
      m_val <= acc_load_value;
      m_ovf <= 1'b0;
    end else if (acc_increment_valid) begin
      {m_ovf, m_val} <= sat_add(m_val, acc_increment);
    end
  end

  assign acc_value    = m_val;
  assign acc_overflow = m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one sample and hold it until accepted (bounded)
  task automatic send(input string tag, input logic [WW-1:0] v, output int waited);
    sample_in    = v;
    sample_valid = 1'b1;
    waited       = 0;
    #1;
    while (!sample_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, " ready"}, 32'(sample_ready), 32'd1);
    check({tag, " increment"}, 32'(acc_increment), 32'(v));
    step();
    sample_valid = 1'b0;
  endtask

  // Called one cycle after the last accept; walks DRAIN, OUTPUT, START into ACCUM
  task automatic finish_window(input string tag, input logic [WW-1:0] exp_res,
                               input logic exp_ovf, input logic [CW-1:0] next_len);
    check({tag, " drain valid"}, 32'(result_valid), 32'd0);
    step();
    check({tag, " valid"}, 32'(result_valid), 32'd1);
    check({tag, " result"}, 32'(result_out), 32'(exp_res));
    check({tag, " overflow"}, 32'(result_overflow), 32'(exp_ovf));
    check({tag, " out ready"}, 32'(sample_ready), 32'd0);
    result_ready  = 1'b1;
    window_length = next_len;
    step();
    result_ready  = 1'b0;
    check({tag, " start valid"}, 32'(result_valid), 32'd0);
    check({tag, " start clear"}, 32'(acc_clear), 32'(EXP_CLR));
    check({tag, " start load"}, 32'(acc_load_valid), 32'(!EXP_CLR));
    check({tag, " start load val"}, 32'(acc_load_value), 32'(EXP_CLR ? 16'h0 : window_bias));
    check({tag, " start ready"}, 32'(sample_ready), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset         = 1'b1;
    window_length = 8'd4;
    sample_in     = '0;
    sample_valid  = 1'b0;
    result_ready  = 1'b0;
    window_bias   = '0;
    #2;
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst result_out", 32'(result_out), 32'd0);
    check("rst result_ovf", 32'(result_overflow), 32'd0);
    check("rst sample_ready", 32'(sample_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    check("post rst clear", 32'(acc_clear), 32'(EXP_CLR));
    step();

    // Window of 4 back-to-back; window_length change mid-window is ignored
    send("t1 s0", 16'd10, w);
    window_length = 8'd1;
    send("t1 s1", 16'd20, w);
    check("t1 bubble1", 32'(w), 32'd0);
    send("t1 s2", 16'hfffb, w);
    check("t1 bubble2", 32'(w), 32'd0);
    send("t1 s3", 16'd7, w);
    check("t1 bubble3", 32'(w), 32'd0);
    finish_window("t1", 16'd32, 1'b0, 8'd3);

    // Saturation mid-window, final increment does not overflow
    send("t2 s0", 16'd32000, w);
    send("t2 s1", 16'd1000, w);
    send("t2 s2", 16'hff9c, w);
    finish_window("t2", 16'd32667, 1'b1, 8'd2);

    // Result backpressure with a sample pending upstream
    send("t3 s0", 16'd5, w);
    send("t3 s1", 16'd6, w);
    check("t3 drain valid", 32'(result_valid), 32'd0);
    step();
    sample_in    = 16'd99;
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t3 hold valid", 32'(result_valid), 32'd1);
      check("t3 hold result", 32'(result_out), 32'd11);
      check("t3 hold ready", 32'(sample_ready), 32'd0);
      step();
    end
    sample_valid  = 1'b0;
    result_ready  = 1'b1;
    window_length = 8'd2;
    step();
    result_ready  = 1'b0;
    check("t3 start clear", 32'(acc_clear), 32'(EXP_CLR));
    check("t3 start valid", 32'(result_valid), 32'd0);
    step();
    send("t3b s0", 16'd1, w);
    send("t3b s1", 16'd1, w);
    finish_window("t3b", 16'd2, 1'b0, 8'd4);

    // Reset after 2 of 4 samples
    send("t4 s0", 16'd100, w);
    send("t4 s1", 16'd200, w);
    reset = 1'b1;
    #1;
    check("t4 rst valid", 32'(result_valid), 32'd0);
    check("t4 rst result", 32'(result_out), 32'd0);
    check("t4 rst ready", 32'(sample_ready), 32'd0);
    step();
    reset = 1'b0;
    check("t4 post clear", 32'(acc_clear), 32'(EXP_CLR));
    step();
    send("t4 s2", 16'd1, w);
    send("t4 s3", 16'd2, w);
    send("t4 s4", 16'd3, w);
    send("t4 s5", 16'd4, w);
    finish_window("t4", 16'd10, 1'b0, 8'd0);

    // window_length=0 acts as 1; idle cycles do not advance the counter
    for (int i = 0; i < 3; i++) step();
    check("t5 idle valid", 32'(result_valid), 32'd0);
    check("t5 idle ready", 32'(sample_ready), 32'd1);
    send("t5 s0", 16'd7, w);
    finish_window("t5a", 16'd7, 1'b0, 8'd0);
    step();
    step();
`ifdef ACC_WINDOW_BIAS_EN
    window_bias = 16'd100;
`endif
    send("t5 s1", 16'hfffd, w);
    finish_window("t5b", 16'hfffd, 1'b0, 8'd2);

`ifdef ACC_WINDOW_BIAS_EN
    // Window starts from the bias value
    send("t6 s0", 16'd1, w);
    send("t6 s1", 16'd2, w);
    finish_window("t6", 16'd103, 1'b0, 8'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
